// File: rtl/syscall_controller.sv
// Syscall controller: reads the syscall code and argument from the register
// file, then prints, halts or flags an unsupported code.
module syscall_controller #(
   parameter int unsigned V0_ADDR    = 2,
   parameter int unsigned A0_ADDR    = 4,
   parameter int unsigned PRINT_CODE = 1,
   parameter int unsigned EXIT_CODE  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        syscall,
   output logic        stall,
   output logic        rf_rd_en,
   output logic [4:0]  rf_rd_addr,
   input  logic [31:0] rf_rd_data,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        halted,
   output logic        bad_code,
   output logic [31:0] bad_code_val,
   output logic [15:0] syscall_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_V0,
      S_RD_A0,
      S_DISPATCH,
      S_PRINT,
      S_ERR,
      S_HALT
   } state_e;

   localparam logic [4:0]  V0_A    = 5'(V0_ADDR);
   localparam logic [4:0]  A0_A    = 5'(A0_ADDR);
   localparam logic [31:0] PRINT_C = 32'(PRINT_CODE);
   localparam logic [31:0] EXIT_C  = 32'(EXIT_CODE);

   state_e      state_q, state_d;
   logic        sys_q;
   logic        edge_det;
   logic [15:0] count_q, count_d;
   logic [31:0] code_q, code_d;
   logic [31:0] arg_q, arg_d;
   logic [31:0] out_data_q, out_data_d;
   logic [31:0] bad_val_q, bad_val_d;

   // gated by rst_n so stall drops the instant reset is asserted
   assign edge_det = rst_n & syscall & ~sys_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (edge_det) begin
               state_d = S_RD_V0;
            end
         end
         S_RD_V0:    state_d = S_RD_A0;
         S_RD_A0:    state_d = S_DISPATCH;
         S_DISPATCH: begin
            if (code_q == PRINT_C) begin
               state_d = S_PRINT;
            end else if (code_q == EXIT_C) begin
               state_d = S_HALT;
            end else begin
               state_d = S_ERR;
            end
         end
         S_PRINT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_ERR:   state_d = S_IDLE;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall      = (state_q != S_IDLE) | edge_det;
      rf_rd_en   = 1'b0;
      rf_rd_addr = 5'd0;
      out_valid  = 1'b0;
      halted     = 1'b0;
      bad_code   = 1'b0;
      case (state_q)
         S_RD_V0: begin
            rf_rd_en   = 1'b1;
            rf_rd_addr = V0_A;
         end
         S_RD_A0: begin
            rf_rd_en   = 1'b1;
            rf_rd_addr = A0_A;
         end
         S_PRINT: out_valid = 1'b1;
         S_ERR:   bad_code  = 1'b1;
         S_HALT:  halted    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sys_q <= 1'b0;
      end else begin
         sys_q <= syscall;
      end
   end

   // captured values are loaded on the transition into the state using them
   always_comb begin
      count_d    = count_q;
      code_d     = code_q;
      arg_d      = arg_q;
      out_data_d = out_data_q;
      bad_val_d  = bad_val_q;
      case (state_q)
         S_IDLE: begin
            if (edge_det) begin
               count_d = count_q + 16'd1;
            end
         end
         S_RD_V0: code_d = rf_rd_data;
         S_RD_A0: arg_d  = rf_rd_data;
         S_DISPATCH: begin
            if (code_q == PRINT_C) begin
               out_data_d = arg_q;
            end else if (code_q != EXIT_C) begin
               bad_val_d = code_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= 16'd0;
         code_q     <= 32'd0;
         arg_q      <= 32'd0;
         out_data_q <= 32'd0;
         bad_val_q  <= 32'd0;
      end else begin
         count_q    <= count_d;
         code_q     <= code_d;
         arg_q      <= arg_d;
         out_data_q <= out_data_d;
         bad_val_q  <= bad_val_d;
      end
   end

   assign out_data      = out_data_q;
   assign bad_code_val  = bad_val_q;
   assign syscall_count = count_q;

endmodule

// File: tb/tb_syscall_controller.sv
// Bench for syscall_controller: vector table, hand-written reset/wrap
// sequences and random syscalls against a transaction-level model.
module tb_syscall_controller;

   localparam int K_PRINT = 0;
   localparam int K_HALT  = 1;
   localparam int K_ERR   = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        syscall = 1'b0;
   logic        stall;
   logic        rf_rd_en;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b0;
   logic        halted;
   logic        bad_code;
   logic [31:0] bad_code_val;
   logic [15:0] syscall_count;

   logic [31:0] regs [32];
   int          total = 0;
   int          bad = 0;
   int          xfers = 0;
   int          exp_xfers = 0;
   logic [15:0] exp_count = 16'd0;

   typedef struct {
      logic [31:0] code;
      logic [31:0] arg;
      int          rdy;
      bit          glitch;
      int          kind;
   } vec_t;

   vec_t vecs [7];

   syscall_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .syscall       (syscall),
      .stall         (stall),
      .rf_rd_en      (rf_rd_en),
      .rf_rd_addr    (rf_rd_addr),
      .rf_rd_data    (rf_rd_data),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready),
      .halted        (halted),
      .bad_code      (bad_code),
      .bad_code_val  (bad_code_val),
      .syscall_count (syscall_count)
   );

   always #5 clk = ~clk;

   assign rf_rd_data = regs[rf_rd_addr];

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         xfers <= xfers + 1;
      end
   end

   function automatic int kind_of(input logic [31:0] code);
      if (code == 32'd1) return K_PRINT;
      if (code == 32'd10) return K_HALT;
      return K_ERR;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic sc);
      @(negedge clk);
      rst_n = 1'b0;
      syscall = sc;
      out_ready = 1'b0;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_rd_en", rf_rd_en, 0);
      chk("rst_rd_addr", rf_rd_addr, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_bad", bad_code, 0);
      chk("rst_data", out_data, 0);
      chk("rst_badval", bad_code_val, 0);
      chk("rst_count", syscall_count, 0);
      exp_count = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // starts at a negedge with the block idle and syscall low
   task automatic transact(input logic [31:0] code, input logic [31:0] arg,
                           input int rdy, input bit glitch, input int kind);
      regs[2] = code;
      regs[4] = arg;
      syscall = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("stall_on_edge", stall, 1);
      exp_count = exp_count + 16'd1;
      @(negedge clk);
      syscall = 1'b0;
      #1;
      chk("v0_en", rf_rd_en, 1);
      chk("v0_addr", rf_rd_addr, 2);
      chk("v0_stall", stall, 1);
      @(negedge clk);
      #1;
      chk("a0_en", rf_rd_en, 1);
      chk("a0_addr", rf_rd_addr, 4);
      if (glitch) syscall = 1'b1;
      @(negedge clk);
      syscall = 1'b0;
      #1;
      chk("disp_en", rf_rd_en, 0);
      chk("disp_addr", rf_rd_addr, 0);
      chk("disp_valid", out_valid, 0);
      chk("disp_stall", stall, 1);
      @(negedge clk);
      case (kind)
         K_PRINT: begin
            for (int i = 0; i <= rdy; i++) begin
               out_ready = (i == rdy);
               #1;
               chk("pr_valid", out_valid, 1);
               chk("pr_data", out_data, arg);
               chk("pr_stall", stall, 1);
               chk("pr_bad", bad_code, 0);
               if (i < rdy) @(negedge clk);
            end
            exp_xfers++;
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            chk("pr_done_valid", out_valid, 0);
            chk("pr_done_stall", stall, 0);
            chk("pr_done_data", out_data, arg);
         end
         K_HALT: begin
            #1;
            chk("halt_on", halted, 1);
            chk("halt_stall", stall, 1);
            chk("halt_valid", out_valid, 0);
            @(negedge clk);
            #1;
            chk("halt_hold", halted, 1);
         end
         default: begin
            #1;
            chk("err_pulse", bad_code, 1);
            chk("err_val", bad_code_val, code);
            chk("err_valid", out_valid, 0);
            @(negedge clk);
            #1;
            chk("err_single", bad_code, 0);
            chk("err_idle", stall, 0);
            chk("err_val_hold", bad_code_val, code);
         end
      endcase
      chk("count", syscall_count, exp_count);
   endtask

   task automatic halt_followup();
      @(negedge clk);
      syscall = 1'b1;
      @(negedge clk);
      syscall = 1'b0;
      @(negedge clk);
      #1;
      chk("halt_ignore", halted, 1);
      chk("halt_ign_stall", stall, 1);
      chk("halt_ign_count", syscall_count, exp_count);
      #2;
      rst_n = 1'b0;
      #1;
      chk("halt_rst_halted", halted, 0);
      chk("halt_rst_stall", stall, 0);
      exp_count = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 + 32'(i);
      vecs[0] = '{32'd1, 32'h0000_002A, 0, 1'b0, K_PRINT};
      vecs[1] = '{32'd1, 32'h0000_002A, 3, 1'b0, K_PRINT};
      vecs[2] = '{32'd7, 32'h1234_5678, 0, 1'b0, K_ERR};
      vecs[3] = '{32'h0000_0101, 32'd9, 0, 1'b1, K_ERR};
      vecs[4] = '{32'h8000_000A, 32'd3, 0, 1'b0, K_ERR};
      vecs[5] = '{32'd10, 32'hFFFF_FFFF, 0, 1'b0, K_HALT};
      vecs[6] = '{32'd1, 32'hDEAD_BEEF, 1, 1'b1, K_PRINT};

      do_reset(1'b0);
      for (int v = 0; v < 7; v++) begin
         transact(vecs[v].code, vecs[v].arg, vecs[v].rdy,
                  vecs[v].glitch, vecs[v].kind);
         if (vecs[v].kind == K_HALT) halt_followup();
      end

      // reset while a print request is pending
      @(negedge clk);
      regs[2] = 32'd1;
      regs[4] = 32'h55;
      syscall = 1'b1;
      @(negedge clk);
      syscall = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("mid_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_rd_en", rf_rd_en, 0);
      chk("mid_rst_count", syscall_count, 0);
      chk("mid_rst_stall", stall, 0);
      exp_count = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("no_resume_stall", stall, 0);
      chk("no_resume_valid", out_valid, 0);

      // reset while reading v0
      @(negedge clk);
      syscall = 1'b1;
      @(negedge clk);
      syscall = 1'b0;
      #1;
      chk("rdv0_en", rf_rd_en, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rdv0_rst_en", rf_rd_en, 0);
      chk("rdv0_rst_addr", rf_rd_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // syscall held high across reset release counts as an edge
      regs[2] = 32'd7;
      do_reset(1'b1);
      #1;
      chk("held_stall", stall, 1);
      exp_count = 16'd1;
      @(negedge clk);
      syscall = 1'b0;
      #1;
      chk("held_rd_en", rf_rd_en, 1);
      chk("held_count", syscall_count, exp_count);
      repeat (3) @(negedge clk);
      #1;
      chk("held_err", bad_code, 1);
      @(negedge clk);
      #1;
      chk("held_idle", stall, 0);

      // counter wrap, with an ignored edge during RD_A0
      @(negedge clk);
      force dut.count_q = 16'hFFFF;
      @(negedge clk);
      release dut.count_q;
      exp_count = 16'hFFFF;
      #1;
      chk("preload", syscall_count, exp_count);
      @(negedge clk);
      transact(32'd1, 32'h0000_0077, 0, 1'b1, K_PRINT);
      @(negedge clk);
      transact(32'd5, 32'd0, 0, 1'b0, K_ERR);

      // random syscalls against the transaction model
      for (int n = 0; n < 40; n++) begin
         int          sel;
         logic [31:0] code;
         logic [31:0] arg;
         sel = $urandom_range(0, 9);
         if (sel < 5) code = 32'd1;
         else if (sel == 5) code = 32'd10;
         else code = $urandom;
         arg = $urandom;
         @(negedge clk);
         transact(code, arg, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), kind_of(code));
         if (kind_of(code) == K_HALT) halt_followup();
      end

      @(negedge clk);
      chk("xfers", 32'(xfers), 32'(exp_xfers));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/syscall_controller.md
SYSCALL_CONTROLLER -- requirements
Module: syscall_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- V0_ADDR, 2, register holding the syscall code
- A0_ADDR, 4, register holding the syscall argument
- PRINT_CODE, 1, code selecting print
- EXIT_CODE, 10, code selecting halt
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- syscall  input  1  syscall indication from control decode; only its rising edge is significant
- stall  output  1  freezes PC and register-file writes while high
- rf_rd_en  output  1  controller owns register-file read port 1
- rf_rd_addr  output  5  read address driven onto port 1 when rf_rd_en=1
- rf_rd_data  input  32  combinational read data from port 1
- out_valid  output  1  print request valid
- out_data  output  32  value to print
- out_ready  input  1  console accepts the print request
- halted  output  1  exit syscall executed
- bad_code  output  1  one-cycle pulse: unsupported code
- bad_code_val  output  32  code that caused the last bad_code pulse
- syscall_count  output  16  number of accepted syscalls

Function
REQ-003 The block SHALL register syscall each cycle; a rising edge SHALL be detected as syscall=1 with the registered copy=0.
REQ-004 States SHALL be IDLE, RD_V0, RD_A0, DISPATCH, PRINT, ERR, HALT.
REQ-005 In IDLE, a detected edge SHALL move to RD_V0 and increment syscall_count, which wraps from 0xFFFF to 0x0000.
REQ-006 stall SHALL be 1 in every state other than IDLE, and SHALL also be 1 combinationally in IDLE during the cycle an edge is detected.
REQ-007 In RD_V0: rf_rd_en=1, rf_rd_addr=V0_ADDR; rf_rd_data SHALL be captured into the code register at the clock edge; next state RD_A0.
REQ-008 In RD_A0: rf_rd_en=1, rf_rd_addr=A0_ADDR; rf_rd_data SHALL be captured into the argument register; next state DISPATCH.
REQ-009 In all other states: rf_rd_en=0, rf_rd_addr=0.
REQ-010 DISPATCH SHALL perform a full 32-bit compare of code.
- code==PRINT_CODE -> PRINT
- code==EXIT_CODE -> HALT
- any other code -> ERR
REQ-011 In PRINT: out_valid=1 and out_data=argument, both held stable until out_valid&&out_ready; on that edge the state SHALL return to IDLE.
REQ-012 out_valid SHALL be 0 and out_data SHALL hold its last value in all states other than PRINT.
REQ-013 In ERR: bad_code=1 for exactly one cycle and bad_code_val is loaded with code; next state IDLE.
REQ-014 HALT SHALL be terminal until reset, with halted=1 and stall=1; syscall edges SHALL be ignored.
REQ-015 Rising edges of syscall outside IDLE SHALL be ignored: no queueing, no count increment, and the edge detector keeps tracking.
REQ-016 Minimum latency SHALL be fixed. For an edge detected at clock edge N: RD_V0 in cycle N+1, RD_A0 in N+2, DISPATCH in N+3, out_valid/halted/bad_code asserted in N+4.
REQ-017 If out_ready is already high on entry to PRINT, the request SHALL complete in one cycle, with IDLE in N+5.

Reset
REQ-018 When rst_n=0, the block SHALL immediately, without waiting for clk, set:
- state to IDLE
- stall, rf_rd_en, out_valid, halted, bad_code to 0
- rf_rd_addr, out_data, bad_code_val, syscall_count, code register, argument register to 0
- the syscall edge register to 0
REQ-019 A reset asserted mid-sequence, including PRINT with out_valid=1 and HALT, SHALL abandon that sequence; after release the block SHALL respond only to a new rising edge.
REQ-020 If syscall is held high across reset release, this SHALL count as a rising edge on the first clock after release.

Verification
REQ-021 Print: regs v0=1, a0=0x0000002A; syscall pulse; out_ready=1 -> out_valid=1 and out_data=0x2A at N+4; stall high for N..N+4; IDLE at N+5; syscall_count=1.
REQ-022 Backpressure: print with out_ready=0 for 3 cycles, then 1 -> out_valid and out_data=0x2A held stable for 4 cycles; a single transfer occurs; stall stays 1 throughout.
REQ-023 Exit: v0=10 -> halted=1 at N+4; a further syscall pulse gives no change and syscall_count stays 1; rst_n low -> halted=0 and stall=0 at once.
REQ-024 Unsupported: v0=0x00000007 -> bad_code single-cycle pulse at N+4, bad_code_val=7; IDLE next cycle; out_valid never asserted.
REQ-025 Reset mid-PRINT: rst_n=0 while out_valid=1 -> out_valid=0 and rf_rd_en=0 with no clock edge; syscall_count=0.
REQ-026 Wrap and ignore: preload 0xFFFF accepted syscalls, then one more -> syscall_count=0x0000; a second edge during RD_A0 is ignored and produces no extra request.
